// File: rtl/nor2_arc_sequencer.sv
// NOR2 self-test sequencer: walks six (A1,A2) vectors NUM_PASSES times, samples ZN_I
// SETTLE cycles after each drive, and reports mismatch count and first failing index.
module nor2_arc_sequencer #(
  parameter int SETTLE     = 3,
  parameter int NUM_PASSES = 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  output logic       A1_O,
  output logic       A2_O,
  input  logic       ZN_I,
  output logic       BUSY,
  output logic       DONE,
  output logic       PASS,
  output logic [3:0] ERR_CNT,
  output logic [2:0] FAIL_IDX
);

  typedef enum logic [2:0] {S_IDLE, S_APPLY, S_WAIT, S_CHECK, S_DONE} state_t;

  localparam logic [2:0] NO_FAIL     = 3'd7;
  localparam logic [2:0] LAST_IDX    = 3'd5;
  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);
  localparam logic [3:0] LAST_PASS   = 4'(NUM_PASSES - 1);
  localparam logic [3:0] ERR_MAX     = 4'd15;

  state_t     state;
  logic [2:0] idx;
  logic [3:0] pass_cnt;
  logic [3:0] settle_cnt;
  logic       mism;
  logic [3:0] err_nxt;
  logic [2:0] idx_nxt;

  // Vector table as {A1,A2}: 00,10,00,01,00,11 -> A1 rise/fall, A2 rise/fall, both high.
  function automatic logic [1:0] vec_drive(input logic [2:0] i);
    logic [1:0] v;
    v = 2'b00;
    case (i)
      3'd1:    v = 2'b10;
      3'd3:    v = 2'b01;
      3'd5:    v = 2'b11;
      default: v = 2'b00;
    endcase
    return v;
  endfunction

  function automatic logic vec_expect(input logic [2:0] i);
    logic z;
    z = 1'b0;
    case (i)
      3'd0, 3'd2, 3'd4: z = 1'b1;
      default:          z = 1'b0;
    endcase
    return z;
  endfunction

  // Equality test in the if lets an unknown ZN_I fall into the mismatch branch.
  always_comb begin
    mism = 1'b0;
    if (state == S_CHECK) begin
      if (ZN_I == vec_expect(idx))
        mism = 1'b0;
      else
        mism = 1'b1;
    end
    err_nxt = ERR_CNT;
    if (mism && (ERR_CNT != ERR_MAX))
      err_nxt = ERR_CNT + 4'd1;
    idx_nxt = (idx < LAST_IDX) ? (idx + 3'd1) : 3'd0;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= S_IDLE;
      idx        <= 3'd0;
      pass_cnt   <= 4'd0;
      settle_cnt <= 4'd0;
      A1_O       <= 1'b0;
      A2_O       <= 1'b0;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
      PASS       <= 1'b0;
      ERR_CNT    <= 4'd0;
      FAIL_IDX   <= NO_FAIL;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (START) begin
            state        <= S_APPLY;
            idx          <= 3'd0;
            pass_cnt     <= 4'd0;
            {A1_O, A2_O} <= vec_drive(3'd0);
            BUSY         <= 1'b1;
            DONE         <= 1'b0;
            PASS         <= 1'b0;
            ERR_CNT      <= 4'd0;
            FAIL_IDX     <= NO_FAIL;
          end
        end

        S_APPLY: begin
          settle_cnt <= SETTLE_LOAD;
          state      <= (SETTLE > 1) ? S_WAIT : S_CHECK;
        end

        // Counter leaves WAIT as it steps to zero, giving SETTLE-1 wait cycles.
        S_WAIT: begin
          settle_cnt <= settle_cnt - 4'd1;
          if (settle_cnt <= 4'd1)
            state <= S_CHECK;
        end

        S_CHECK: begin
          ERR_CNT <= err_nxt;
          if (mism && (FAIL_IDX == NO_FAIL))
            FAIL_IDX <= idx;
          if ((idx < LAST_IDX) || (pass_cnt < LAST_PASS)) begin
            state        <= S_APPLY;
            idx          <= idx_nxt;
            {A1_O, A2_O} <= vec_drive(idx_nxt);
            if (idx >= LAST_IDX)
              pass_cnt <= pass_cnt + 4'd1;
          end else begin
            state <= S_DONE;
            A1_O  <= 1'b0;
            A2_O  <= 1'b0;
            BUSY  <= 1'b0;
            DONE  <= 1'b1;
            PASS  <= (err_nxt == 4'd0);
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
